// File: rtl/period_meter.sv
`default_nettype none
// ============================================================================
//  Module   : period_meter
//  Purpose  : Measures the period and high time of a slow asynchronous input
//             in CLK cycles and presents each result on a valid/ready
//             interface. A missing input is reported by a sticky timeout flag.
//  Ports    : CLK        - system clock
//             RST        - asynchronous active-high reset
//             sig_in     - asynchronous signal to be measured
//             period     - CLK cycles between the last two rising edges
//             high_time  - CLK cycles from measured rise to following fall
//             valid      - result available, held until accepted
//             ready      - consumer accepts the result when valid && ready
//             overrun    - sticky: a result was overwritten before acceptance
//             timeout    - sticky: no rising edge within TIMEOUT_CYCLES
//  Revision : 1.0 - initial release
// ============================================================================
module period_meter #(
  parameter int  CLOCK_SPEED_MHZ = 12,
  parameter real TIMEOUT_MS      = 2000.0,
  parameter int  WIDTH           = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  input  logic             ready,
  output logic             overrun,
  output logic             timeout
);

  // TIMEOUT_MS is real so short timeouts (fractions of a ms) can be set;
  // round to the nearest whole cycle.
  localparam logic [WIDTH-1:0] TIMEOUT_CYCLES =
    WIDTH'($rtoi(real'(CLOCK_SPEED_MHZ) * 1000.0 * TIMEOUT_MS + 0.5));

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             s1_q, s2_q, prev_q;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_cap_q, hi_cap_d;
  logic             hi_seen_q, hi_seen_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_time_q, high_time_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;

  logic w_rise_det;
  logic w_fall_det;
  logic w_accept;

  assign w_rise_det = s2_q & ~prev_q;
  assign w_fall_det = ~s2_q & prev_q;
  assign w_accept   = valid_q & ready;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      s1_q        <= 1'b0;
      s2_q        <= 1'b0;
      prev_q      <= 1'b0;
      cnt_q       <= '0;
      hi_cap_q    <= '0;
      hi_seen_q   <= 1'b0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      s1_q        <= sig_in;
      s2_q        <= s1_q;
      prev_q      <= s2_q;
      cnt_q       <= cnt_d;
      hi_cap_q    <= hi_cap_d;
      hi_seen_q   <= hi_seen_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_cap_d    = hi_cap_q;
    hi_seen_d   = hi_seen_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    timeout_d   = timeout_q;

    // An accepted transfer drains the result and clears the overrun flag.
    // A result loading in the same cycle re-asserts valid below.
    if (w_accept) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        // First rise after reset or timeout only arms the measurement.
        if (w_rise_det) begin
          state_d   = MEASURE;
          cnt_d     = WIDTH'(1);
          hi_cap_d  = '0;
          hi_seen_d = 1'b0;
        end
      end

      MEASURE: begin
        if (w_rise_det) begin
          // Rise takes priority over a coincident timeout.
          period_d    = cnt_q;
          high_time_d = hi_cap_q;
          valid_d     = 1'b1;
          timeout_d   = 1'b0;
          cnt_d       = WIDTH'(1);
          hi_cap_d    = '0;
          hi_seen_d   = 1'b0;
          if (valid_q && !ready) begin
            overrun_d = 1'b1;
          end
        end else if (cnt_q == TIMEOUT_CYCLES) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
          // Only the first fall after the rise defines the high time.
          if (w_fall_det && !hi_seen_q) begin
            hi_cap_d  = cnt_q;
            hi_seen_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign period    = period_q;
  assign high_time = high_time_q;
  assign valid     = valid_q;
  assign overrun   = overrun_q;
  assign timeout   = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_period_meter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_period_meter
//  Purpose  : Directed self-checking bench for period_meter, built with
//             TIMEOUT_CYCLES = 1 MHz * 1000 * 0.05 ms = 50.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_period_meter;

  logic        CLK;
  logic        RST;
  logic        sig_in;
  logic        ready;
  logic [31:0] period;
  logic [31:0] high_time;
  logic        valid;
  logic        overrun;
  logic        timeout;

  int checks;
  int failures;

  period_meter #(
    .CLOCK_SPEED_MHZ(1),
    .TIMEOUT_MS     (0.05),
    .WIDTH          (32)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .sig_in   (sig_in),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .ready    (ready),
    .overrun  (overrun),
    .timeout  (timeout)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Drive sig_in for one cycle. A rise driven at step i is detected in cycle
  // i+2 and its result is visible after step i+2 returns.
  task automatic step(input logic v);
    sig_in = v;
    tick();
  endtask

  function automatic logic wave(int i, int p, int h);
    return (i % p) < h;
  endfunction

  task automatic do_reset();
    RST    = 1'b1;
    sig_in = 1'b0;
    ready  = 1'b0;
    repeat (3) tick();
    RST = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    RST    = 1'b1;
    sig_in = 1'b0;
    ready  = 1'b0;
    repeat (3) tick();
    checks++; if (period !== 32'd0) begin failures++; $display("FAIL reset_period got=%0d exp=0", period); end
    checks++; if (high_time !== 32'd0) begin failures++; $display("FAIL reset_high got=%0d exp=0", high_time); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid); end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%0b exp=0", timeout); end
    RST = 1'b0;
    repeat (3) tick();
  endtask

  // Period 12, high 6, always ready: one valid pulse per rise after the first.
  task automatic test_basic();
    logic exp_v;
    do_reset();
    ready = 1'b1;
    for (int i = 0; i < 48; i++) begin
      step(wave(i, 12, 6));
      exp_v = (i >= 12) && (i % 12 == 2);
      checks++; if (valid !== exp_v) begin failures++; $display("FAIL basic_valid i=%0d got=%0b exp=%0b", i, valid, exp_v); end
      if (exp_v) begin
        checks++; if (period !== 32'd12) begin failures++; $display("FAIL basic_period i=%0d got=%0d exp=12", i, period); end
        checks++; if (high_time !== 32'd6) begin failures++; $display("FAIL basic_high i=%0d got=%0d exp=6", i, high_time); end
      end
    end
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL basic_overrun got=%0b exp=0", overrun); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL basic_timeout got=%0b exp=0", timeout); end
  endtask

  // Period 20, high 3, consumer stalled for three rises, then accepts.
  task automatic test_overrun();
    do_reset();
    for (int i = 0; i < 51; i++) begin
      ready = (i == 50);
      step(wave(i, 20, 3));
      if (i == 21) begin
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL ovr_valid_early got=%0b exp=0", valid); end
      end
      if (i == 22) begin
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL ovr_valid_r2 got=%0b exp=1", valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_overrun_r2 got=%0b exp=0", overrun); end
      end
      if (i == 41) begin
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL ovr_valid_held got=%0b exp=1", valid); end
        checks++; if (period !== 32'd20) begin failures++; $display("FAIL ovr_period_held got=%0d exp=20", period); end
      end
      if (i == 42) begin
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_overrun_r3 got=%0b exp=1", overrun); end
        checks++; if (period !== 32'd20) begin failures++; $display("FAIL ovr_period got=%0d exp=20", period); end
        checks++; if (high_time !== 32'd3) begin failures++; $display("FAIL ovr_high got=%0d exp=3", high_time); end
      end
      if (i == 50) begin
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL ovr_valid_acc got=%0b exp=0", valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_overrun_acc got=%0b exp=0", overrun); end
      end
    end
    ready = 1'b0;
  endtask

  // One rise then silence: timeout after 50 cycles; two rises 10 apart recover.
  task automatic test_timeout();
    do_reset();
    ready = 1'b1;
    for (int i = 0; i < 76; i++) begin
      step((i < 5) || ((i >= 60) && wave(i - 60, 10, 5)));
      if (i < 72) begin
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL to_valid i=%0d got=%0b exp=0", i, valid); end
      end
      if (i == 51) begin
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL to_early got=%0b exp=0", timeout); end
      end
      if (i == 52) begin
        checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL to_set got=%0b exp=1", timeout); end
        checks++; if (period !== 32'd0) begin failures++; $display("FAIL to_period_kept got=%0d exp=0", period); end
      end
      if (i == 71) begin
        checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL to_sticky got=%0b exp=1", timeout); end
      end
      if (i == 72) begin
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL to_rec_valid got=%0b exp=1", valid); end
        checks++; if (period !== 32'd10) begin failures++; $display("FAIL to_rec_period got=%0d exp=10", period); end
        checks++; if (high_time !== 32'd5) begin failures++; $display("FAIL to_rec_high got=%0d exp=5", high_time); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL to_rec_clear got=%0b exp=0", timeout); end
      end
    end
  endtask

  // Rises exactly TIMEOUT_CYCLES apart: the rise wins.
  task automatic test_boundary();
    do_reset();
    ready = 1'b1;
    for (int i = 0; i < 56; i++) begin
      step(wave(i, 50, 10));
      if (i == 51) begin
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL bnd_valid_early got=%0b exp=0", valid); end
      end
      if (i == 52) begin
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL bnd_valid got=%0b exp=1", valid); end
        checks++; if (period !== 32'd50) begin failures++; $display("FAIL bnd_period got=%0d exp=50", period); end
        checks++; if (high_time !== 32'd10) begin failures++; $display("FAIL bnd_high got=%0d exp=10", high_time); end
      end
      if (i >= 51) begin
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL bnd_timeout i=%0d got=%0b exp=0", i, timeout); end
      end
    end
  endtask

  // Period-30 wave, reset pulsed mid-measurement with a result pending.
  task automatic test_mid_reset();
    do_reset();
    for (int i = 0; i < 123; i++) begin
      if (i == 66) begin
        RST = 1'b1;
        #1;
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL mr_valid got=%0b exp=0", valid); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL mr_overrun got=%0b exp=0", overrun); end
        checks++; if (period !== 32'd0) begin failures++; $display("FAIL mr_period got=%0d exp=0", period); end
        checks++; if (high_time !== 32'd0) begin failures++; $display("FAIL mr_high got=%0d exp=0", high_time); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL mr_timeout got=%0b exp=0", timeout); end
      end
      if (i == 67) RST = 1'b0;
      step(wave(i, 30, 3));
      if (i == 32) begin
        checks++; if (valid !== 1'b1 || period !== 32'd30) begin failures++; $display("FAIL mr_first got=%0b/%0d exp=1/30", valid, period); end
      end
      if (i == 62) begin
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL mr_pre_overrun got=%0b exp=1", overrun); end
      end
      if (i >= 67 && i < 122) begin
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL mr_rearm_valid i=%0d got=%0b exp=0", i, valid); end
      end
      if (i == 122) begin
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL mr_post_valid got=%0b exp=1", valid); end
        checks++; if (period !== 32'd30) begin failures++; $display("FAIL mr_post_period got=%0d exp=30", period); end
        checks++; if (high_time !== 32'd3) begin failures++; $display("FAIL mr_post_high got=%0d exp=3", high_time); end
      end
    end
  endtask

  // New result loads in the same cycle the pending one is accepted.
  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 34; i++) begin
      ready = (i >= 30);
      step((i < 6) || ((i >= 12) && (i < 16)) || ((i >= 28) && (i < 32)));
      if (i == 14) begin
        checks++; if (valid !== 1'b1 || period !== 32'd12 || high_time !== 32'd6) begin failures++; $display("FAIL b2b_first got=%0b/%0d/%0d exp=1/12/6", valid, period, high_time); end
      end
      if (i == 29) begin
        checks++; if (valid !== 1'b1 || period !== 32'd12) begin failures++; $display("FAIL b2b_held got=%0b/%0d exp=1/12", valid, period); end
      end
      if (i == 30) begin
        checks++; if (valid !== 1'b1) begin failures++; $display("FAIL b2b_valid got=%0b exp=1", valid); end
        checks++; if (period !== 32'd16) begin failures++; $display("FAIL b2b_period got=%0d exp=16", period); end
        checks++; if (high_time !== 32'd4) begin failures++; $display("FAIL b2b_high got=%0d exp=4", high_time); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_overrun got=%0b exp=0", overrun); end
      end
      if (i == 31) begin
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0b exp=0", valid); end
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RST      = 1'b1;
    sig_in   = 1'b0;
    ready    = 1'b0;
    test_reset();
    test_basic();
    test_overrun();
    test_timeout();
    test_boundary();
    test_mid_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/period_meter.md
Name: period_meter

Overview:
- Measures the period and high time of a slow digital input, in CLK cycles, e.g. the toggle output of the team's clock divider or an external square wave.
- The input is asynchronous. The block synchronises it, detects edges, counts CLK cycles between successive rising edges, and presents each result on a valid/ready interface.
- A missing signal is reported via a timeout flag.

Parameters:
- CLOCK_SPEED_MHZ, 12, CLK frequency in MHz.
- TIMEOUT_MS, 2000, maximum time between rising edges before the block reports a timeout.
- WIDTH, 32, width of the result fields. Must hold TIMEOUT_CYCLES = CLOCK_SPEED_MHZ*1000*TIMEOUT_MS.

Ports:
- CLK  input  1  system clock.
- RST  input  1  asynchronous, active-high reset.
- sig_in  input  1  asynchronous signal to be measured.
- period  output  WIDTH  CLK cycles between the last two rising edges.
- high_time  output  WIDTH  CLK cycles from the measured rising edge to the following falling edge.
- valid  output  1  result available; held until accepted.
- ready  input  1  consumer accepts the result when valid && ready.
- overrun  output  1  sticky: a result was overwritten before it was accepted.
- timeout  output  1  sticky: no rising edge seen within TIMEOUT_CYCLES.

Behaviour:
- Reset values (RST high, asynchronous): period=0, high_time=0, valid=0, overrun=0, timeout=0. Internal state: state=IDLE, cnt=0, sync flops=0.
- Synchroniser: 2-flop synchroniser on sig_in, then a registered previous value.
  - rise_det = s2 & ~prev; fall_det = ~s2 & prev.
  - Detection lags the sig_in edge by 2-3 CLK cycles, but intervals between edges are preserved exactly for stimulus that is synchronous to CLK.
- Counter cnt, WIDTH bits:
  - Loaded with 1 in the cycle after a rise_det; increments by 1 every cycle after that.
  - Therefore k cycles after a rise_det, cnt = k.
  - cnt never exceeds TIMEOUT_CYCLES.
- State IDLE:
  - Waits for a rise_det. No result is produced; the first edge only arms the measurement.
  - rise_det -> MEASURE, cnt loaded, hi_cap cleared.
- State MEASURE:
  - fall_det: the internal register hi_cap captures cnt (the first fall only).
  - rise_det: period <= cnt, high_time <= hi_cap, valid <= 1, timeout <= 0. cnt reloads to 1 and the block stays in MEASURE, so measurements run back to back with every rising edge yielding a result.
  - cnt == TIMEOUT_CYCLES with no rise_det in that cycle: timeout <= 1, state -> IDLE, no result, and period/high_time keep their previous values.
  - rise_det in the same cycle as cnt == TIMEOUT_CYCLES: the rise wins, a valid result is produced, and no timeout is flagged.
  - If no fall is seen before the next rise, high_time = 0.
- Handshake:
  - valid stays 1, with period/high_time stable, until a cycle with valid && ready.
  - That cycle clears valid, unless a new result loads in the same cycle. In that case the new result is loaded, valid stays 1, and overrun is not set.
  - A new result while valid && !ready: the old result is overwritten, overrun <= 1.
  - overrun clears only on the next accepted transfer (valid && ready) or on RST.
- Limits:
  - Minimum measurable period is 2 CLK cycles; shorter periods are undefined.
  - Input high or low for fewer than 1 CLK cycle may be missed.
- Reset mid-measurement: all state is discarded immediately. After RST deasserts, the first rising edge only re-arms the measurement.

Test Plan:
- sig_in synchronous square wave, period 12, high 6, ready=1 -> first rise gives no valid; each later rise gives one valid pulse with period=12, high_time=6; overrun=0, timeout=0.
- Period 20, high 3, ready=0 for three rising edges, then ready=1 -> valid held from the second rise; overrun=1 after the third rise; the accepted result is period=20, high_time=3; overrun clears on acceptance.
- TIMEOUT_MS tuned so TIMEOUT_CYCLES=50; one rise, then sig_in held low -> timeout=1 exactly 50 cycles after the rise's cnt load; valid stays 0; the next two rises 10 cycles apart give period=10 and clear timeout.
- TIMEOUT_CYCLES=50, rises exactly 50 cycles apart -> period=50 reported, timeout stays 0.
- RST pulsed 5 cycles after a rise in a period-30 wave -> all outputs 0; the next rise produces no result; the following rise gives period=30.
- Result loaded while valid=1 and ready=1 in the same cycle -> valid stays 1, new values present, overrun=0.
